img_stream_tx: RTL
==================

IMG_STREAM_TX -- requirements
Module: img_stream_tx

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'h00, fill value for unused upper bytes of a frame's final partial word.
REQ-002 SHALL have port clock  input  1  sole clock; all state rises on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port len_data  input  32  byte count of the next frame.
REQ-005 SHALL have port len_valid  input  1  len_data valid.
REQ-006 SHALL have port len_ready  output  1  length accepted this cycle when high with len_valid.
REQ-007 SHALL have port in_byte  input  8  payload byte.
REQ-008 SHALL have port in_valid  input  1  in_byte valid.
REQ-009 SHALL have port upstream_stall  output  1  high = in_byte not accepted this cycle.
REQ-010 SHALL have port out_data  output  32  stream word.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_last  output  1  out_data is the final word of the frame; qualified by out_valid.
REQ-013 SHALL have port downstream_stall  input  1  high = sink not taking out_data this cycle.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE or out_valid is high.

Function
REQ-015 SHALL emit per frame one header word equal to the byte count N, then ceil(N/4) payload words.
REQ-016 SHALL place payload byte k of a word at bits [8k+7:8k], so the first byte received occupies the LSB.
REQ-017 SHALL fill the unused upper bytes of the final partial word with PAD_BYTE.
REQ-018 SHALL transfer an input byte only when in_valid && !upstream_stall.
REQ-019 SHALL transfer an output word only when out_valid && !downstream_stall.
REQ-020 SHALL hold out_data, out_valid and out_last stable while out_valid && downstream_stall.
REQ-021 SHALL implement states IDLE, HEADER and PACK.
REQ-022 In IDLE, len_ready SHALL be 1; on len_valid the block SHALL latch N into a 32-bit remaining counter and go to HEADER.
REQ-023 In HEADER, the header word SHALL be loaded into the output register on the first cycle the register is free (empty, or emptying this cycle); go to PACK if N>0, otherwise to IDLE with out_last=1.
REQ-024 out_valid for the header SHALL rise on the cycle after the len handshake when the output register is free.
REQ-025 In PACK, upstream_stall SHALL equal (out_valid && downstream_stall); in every other state it SHALL be 1.
REQ-026 Each accepted byte SHALL decrement remaining and advance a 2-bit lane index.
REQ-027 A word SHALL be loaded into the output register on the same edge that accepts lane-3 byte or the byte bringing remaining to 0; out_valid is high the following cycle.
REQ-028 The byte bringing remaining to 0 SHALL set out_last on that word, return to IDLE and clear the lane index.
REQ-029 A new len_valid SHALL be accepted in IDLE while the previous last word is still stalled at the output.
REQ-030 Sustained throughput SHALL be one byte per cycle with no bubbles across word boundaries when downstream_stall is low.
REQ-031 len_valid outside IDLE SHALL be ignored (len_ready low).

Reset
REQ-032 On reset low, asynchronously: state=IDLE, remaining=0, lane=0, out_valid=0, out_last=0, out_data=0, busy=0, len_ready=1, upstream_stall=1.
REQ-033 A reset mid-frame SHALL discard the partial word and any pending output word without emitting it.

Structure
REQ-034 Package img_stream_pkg SHALL hold the state enum, WORD_BYTES=4, BYTE_W=8 and WORD_W=32.
REQ-035 The output register/handshake SHALL be a sub-module img_stream_out_reg, one word deep, with load/free signalling.

Verification
REQ-036 N=8, bytes 01..08, no stall -> 0x00000008, 0x04030201, 0x08070605 (out_last=1), words on consecutive handshakes.
REQ-037 N=5, bytes 01..05 -> 0x00000005, 0x04030201, 0x00000005 (out_last=1, bytes 3..1 = PAD_BYTE).
REQ-038 N=0 -> single word 0x00000000 with out_last=1; upstream_stall stays 1; back to IDLE.
REQ-039 N=4, downstream_stall high 3 cycles while the header is valid -> out_data held at 0x00000004, upstream_stall=1 for those cycles, no byte lost.
REQ-040 Reset low after 3 bytes of N=8 -> out_valid=0 immediately, len_ready=1; next frame N=4 with bytes AA..DD -> 0x00000004, 0xDDCCBBAA (last).
REQ-041 Back-to-back N=1 (byte 11) then N=2 (bytes 22,33) -> 0x1, 0x00000011 (last), 0x2, 0x00003322 (last).

Source files
------------

// File: rtl/img_stream_pkg.sv
// Shared types and sizes for the image stream transmitter.
package img_stream_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PACK
  } state_e;

endpackage

// File: rtl/img_stream_out_reg.sv
// One-word output register with valid/stall handshake.
// Free when empty or when the held word leaves this cycle.
module img_stream_out_reg
  import img_stream_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  input  logic              downstream_stall,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              free
);

  assign free = !out_valid || !downstream_stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
      out_last  <= load_last;
    end else if (out_valid && !downstream_stall) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/img_stream_tx.sv
// Byte-to-word frame packer: emits a length header word, then
// little-endian packed payload words with a padded final word.
module img_stream_tx
  import img_stream_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       len_data,
  input  logic              len_valid,
  output logic              len_ready,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  output logic              upstream_stall,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              downstream_stall,
  output logic              busy
);

  state_e      state, state_n;
  logic [31:0] remaining, rem_n;
  logic [1:0]  lane, lane_n;
  logic [23:0] acc;

  logic              load;
  logic [WORD_W-1:0] load_data;
  logic              load_last;
  logic              free;
  logic              byte_take;
  logic [WORD_W-1:0] word;

  assign upstream_stall = (state != PACK)
                        || (out_valid && downstream_stall);
  assign byte_take = in_valid && !upstream_stall;
  assign busy = (state != IDLE) || out_valid;

  // Lanes below the current one come from acc, above it are pad.
  always_comb begin
    word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (2'(i) < lane)
        word[i*BYTE_W +: BYTE_W] = acc[i*BYTE_W +: BYTE_W];
      else if (2'(i) == lane)
        word[i*BYTE_W +: BYTE_W] = in_byte;
      else
        word[i*BYTE_W +: BYTE_W] = PAD_BYTE;
    end
  end

  always_comb begin
    state_n   = state;
    rem_n     = remaining;
    lane_n    = lane;
    len_ready = 1'b0;
    load      = 1'b0;
    load_data = remaining;
    load_last = 1'b0;
    unique case (state)
      IDLE: begin
        len_ready = 1'b1;
        if (len_valid) begin
          rem_n   = len_data;
          state_n = HEADER;
        end
      end
      HEADER: begin
        if (free) begin
          load      = 1'b1;
          load_last = (remaining == 32'd0);
          state_n   = (remaining == 32'd0) ? IDLE : PACK;
        end
      end
      PACK: begin
        if (byte_take) begin
          rem_n  = remaining - 32'd1;
          lane_n = lane + 2'd1;
          if (lane == 2'd3 || remaining == 32'd1) begin
            load      = 1'b1;
            load_data = word;
          end
          if (remaining == 32'd1) begin
            load_last = 1'b1;
            lane_n    = 2'd0;
            state_n   = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      lane      <= '0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      lane      <= lane_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else begin
      for (int i = 0; i < WORD_BYTES - 1; i++)
        if (byte_take && lane == 2'(i))
          acc[i*BYTE_W +: BYTE_W] <= in_byte;
    end
  end

  img_stream_out_reg u_out (
    .clock            (clock),
    .reset            (reset),
    .load             (load),
    .load_data        (load_data),
    .load_last        (load_last),
    .downstream_stall (downstream_stall),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_last         (out_last),
    .free             (free)
  );

endmodule
